// File: rtl/jtframe_ioctl_pkg.sv
// Shared definitions for the ioctl byte-to-word packer: byte-lane enables and
// the FIFO entry layout {word address, 16-bit data, 2-bit byte enable}.
package jtframe_ioctl_pkg;

  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
  localparam logic [1:0] BE_ALL = 2'b11;

  // Bits carried next to the word address in every FIFO entry: data + enables.
  localparam int ENTRY_PAYLOAD_W = 18;

  function automatic int entry_w(input int addr_w);
    return addr_w + ENTRY_PAYLOAD_W;
  endfunction

endpackage

// File: rtl/jtframe_ioctl_fifo.sv
// Single-clock FIFO with registered storage. A push while full is accepted
// only when a pop frees the head slot on the same edge.
module jtframe_ioctl_fifo #(
  parameter int W  = 40,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // One extra pointer bit tells a full ring apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every always_ff
  // samples the pre-edge values of the others, whatever the evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage carries no reset; the pointers alone define which entries
  // are valid, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jtframe_ioctl_packer.sv
// Packs ioctl ROM-download bytes into 16-bit SDRAM words with byte enables,
// buffering them in a small FIFO so SDRAM write latency never stalls the SPI.
module jtframe_ioctl_packer
  import jtframe_ioctl_pkg::*;
#(
  parameter int FIFO_AW = 2,
  parameter int ADDR_W  = 22
) (
  input  logic              clk_rom,
  input  logic              rst_n,
  input  logic              ioctl_rom,
  input  logic              ioctl_wr,
  input  logic [25:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_be,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              ovf_err,
  output logic              range_err
);

  localparam int EW = entry_w(ADDR_W);

  // Assembler register and its next value
  logic              asm_valid;
  logic [ADDR_W-1:0] asm_addr;
  logic [15:0]       asm_data;
  logic [1:0]        asm_be;
  logic              nxt_valid;
  logic [ADDR_W-1:0] nxt_addr;
  logic [15:0]       nxt_data;
  logic [1:0]        nxt_be;

  logic              rom_q;
  logic              busy;
  logic              accept;
  logic              in_range;
  logic              byte_ok;
  logic              lane;
  logic [1:0]        lane_be;
  logic [ADDR_W-1:0] byte_waddr;
  logic              full_word;
  logic              live;
  logic              addr_change;
  logic              fall;
  logic              push;
  logic [EW-1:0]     push_word;
  logic [EW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign accept      = ioctl_wr & ioctl_rom;
  assign in_range    = (ioctl_addr >> (ADDR_W + 1)) == '0;
  assign byte_ok     = accept & in_range;
  assign lane        = ioctl_addr[0];
  assign lane_be     = lane ? BE_HI : BE_LO;
  assign byte_waddr  = ioctl_addr[ADDR_W:1];
  assign full_word   = asm_valid & (asm_be == BE_ALL);
  // A completed word is already on its way out, so it no longer accepts merges.
  assign live        = asm_valid & ~full_word;
  assign addr_change = byte_ok & live & (byte_waddr != asm_addr);
  assign fall        = rom_q & ~ioctl_rom;
  assign pop         = prog_rdy & ~fifo_empty;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    nxt_valid = asm_valid;
    nxt_addr  = asm_addr;
    nxt_data  = asm_data;
    nxt_be    = asm_be;
    push      = 1'b0;
    push_word = {asm_addr, asm_data, asm_be};

    if (full_word || addr_change) push = 1'b1;

    if (full_word) begin
      nxt_valid = 1'b0;
      nxt_be    = '0;
    end

    if (byte_ok) begin
      if (!live || byte_waddr != asm_addr) begin
        nxt_valid = 1'b1;
        nxt_addr  = byte_waddr;
        nxt_data  = lane ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
        nxt_be    = lane_be;
      end else begin
        if (lane) nxt_data[15:8] = ioctl_dout;
        else      nxt_data[7:0]  = ioctl_dout;
        nxt_be = asm_be | lane_be;
      end
    end

    // Flush takes the post-merge word; it never coincides with another push
    // because a falling window admits no byte and a completed word empties
    // the assembler.
    if (fall && nxt_valid && !push) begin
      push      = 1'b1;
      push_word = {nxt_addr, nxt_data, nxt_be};
      nxt_valid = 1'b0;
      nxt_be    = '0;
    end
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      asm_valid <= 1'b0;
      asm_addr  <= '0;
      asm_data  <= '0;
      asm_be    <= '0;
      rom_q     <= 1'b0;
      busy      <= 1'b0;
      ovf_err   <= 1'b0;
      range_err <= 1'b0;
    end else begin
      asm_valid <= nxt_valid;
      asm_addr  <= nxt_addr;
      asm_data  <= nxt_data;
      asm_be    <= nxt_be;
      rom_q     <= ioctl_rom;
      busy      <= ioctl_rom | asm_valid | ~fifo_empty;
      if (accept && !in_range)           range_err <= 1'b1;
      if (push && fifo_full && !pop)     ovf_err   <= 1'b1;
    end
  end

  jtframe_ioctl_fifo #(
    .W  (EW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk_rom),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign prog_we    = ~fifo_empty;
  assign dwnld_busy = busy;
  // Mask the unreset storage so every output reads zero while nothing is queued.
  assign {prog_addr, prog_data, prog_be} = fifo_empty ? '0 : head;

endmodule
